// File: rtl/seg7_count_disp_pkg.sv
// Shared constants for the two-digit 7-segment display stage: segment
// patterns (active-low, DP off), anode patterns, scanner state encoding
// and the binary-to-decimal digit split helpers.
package seg7_count_disp_pkg;

    typedef enum logic {
        S_ONES = 1'b0,
        S_TENS = 1'b1
    } scan_state_e;

    // Segment patterns: bit7 = DP, bits6..0 = g,f,e,d,c,b,a, active-low.
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Anode patterns, active-low: bit0 = ones digit, bit1 = tens digit.
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    // Ones digit of a 0..15 value.
    function automatic logic [3:0] ones_digit(input logic [3:0] value);
        return (value >= 4'd10) ? (value - 4'd10) : value;
    endfunction

    // Tens digit of a 0..15 value (only 0 or 1 are possible).
    function automatic logic [3:0] tens_digit(input logic [3:0] value);
        return (value >= 4'd10) ? 4'd1 : 4'd0;
    endfunction

endpackage

// File: rtl/seg7_count_disp_if.sv
// Bundle between the counter stage (master: drives COUNT) and the display
// stage (slave: drives the segment and anode lines).
interface seg7_count_disp_if;
    logic [3:0] COUNT;
    logic [7:0] SEG;
    logic [1:0] AN;

    modport master (output COUNT, input SEG, input AN);
    modport slave  (input COUNT, output SEG, output AN);
endinterface

// File: rtl/seg7_count_disp_dec.sv
// Purely combinational BCD digit to active-low 7-segment decoder.
// Codes above 9 blank the digit so a corrupted value never lights garbage.
module seg7_dec
    import seg7_count_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    // Table lookup, DP always off.
    always_comb begin
        seg_o = SEG_OFF;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_count_disp.sv
// Two-digit time-multiplexed display of a 0..15 count on a common-anode
// 7-segment display. A prescaler defines digit slots; a two-state scanner
// alternates ones/tens; each slot's digit is snapshotted at the slot
// boundary so it stays stable; the first GHOST_CYC cycles of each slot are
// dark to avoid ghosting; outputs are registered.
module seg7_count_disp
    import seg7_count_disp_pkg::*;
#(
    parameter int SCAN_MAX  = 50000,
    parameter int GHOST_CYC = 1,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    seg7_count_disp_if.slave disp
);

    localparam int CW = $clog2(SCAN_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_MAX - 1);

    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    scan_state_e   state_q, state_d;
    logic [3:0]    count_q;
    logic [3:0]    digit_q, digit_d;
    // Cleared by reset until the first slot boundary: no digit has been
    // captured yet, so the slot right after reset stays dark.
    logic          snap_vld_q, snap_vld_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          tick;
    logic          ghost;
    logic [7:0]    dec_seg;

    seg7_dec u_dec (
        .digit_i (digit_q),
        .seg_o   (dec_seg)
    );

    // Anti-ghosting window at the start of every slot.
    if (GHOST_CYC == 0) begin : g_no_ghost
        assign ghost = 1'b0;
    end else begin : g_ghost
        assign ghost = (scan_cnt_q < CW'(GHOST_CYC));
    end

    // Prescaler: count 0..SCAN_MAX-1, tick on the last cycle of a slot.
    always_comb begin
        tick       = (scan_cnt_q == CNT_LAST);
        scan_cnt_d = tick ? '0 : scan_cnt_q + 1'b1;
    end

    // Scanner: toggle on tick and capture the digit for the upcoming slot.
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        snap_vld_d = snap_vld_q;
        if (tick) begin
            snap_vld_d = 1'b1;
            if (state_q == S_ONES) begin
                state_d = S_TENS;
                digit_d = tens_digit(count_q);
            end else begin
                state_d = S_ONES;
                digit_d = ones_digit(count_q);
            end
        end
    end

    // Output selection: dark by default, one anode at most.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (snap_vld_q && !ghost) begin
            if (state_q == S_ONES) begin
                an_d  = AN_ONES;
                seg_d = dec_seg;
            end else if (!(LZ_BLANK && (digit_q == 4'd0))) begin
                an_d  = AN_TENS;
                seg_d = dec_seg;
            end
        end
    end

    // State, input and output registers with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scan_cnt_q <= '0;
            state_q    <= S_ONES;
            count_q    <= 4'd0;
            digit_q    <= 4'd0;
            snap_vld_q <= 1'b0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            state_q    <= state_d;
            count_q    <= disp.COUNT;
            digit_q    <= digit_d;
            snap_vld_q <= snap_vld_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign disp.SEG = seg_q;
    assign disp.AN  = an_q;

endmodule

// File: tb/tb_seg7_count_disp.sv
// Directed bench for seg7_count_disp with SCAN_MAX=4, GHOST_CYC=1.
// Two instances share clock, reset and COUNT: one with leading-zero
// blanking, one without. Outputs are sampled on the falling edge.
module tb_seg7_count_disp;
    import seg7_count_disp_pkg::*;

    localparam int SCAN_MAX  = 4;
    localparam int GHOST_CYC = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;
    bit   inv_en   = 1'b1;

    always #10 clk = ~clk;

    seg7_count_disp_if if_lz ();
    seg7_count_disp_if if_nz ();

    seg7_count_disp #(.SCAN_MAX(SCAN_MAX), .GHOST_CYC(GHOST_CYC), .LZ_BLANK(1'b1)) dut_lz (
        .CLK   (clk),
        .RESET (rst_n),
        .disp  (if_lz.slave)
    );

    seg7_count_disp #(.SCAN_MAX(SCAN_MAX), .GHOST_CYC(GHOST_CYC), .LZ_BLANK(1'b0)) dut_nz (
        .CLK   (clk),
        .RESET (rst_n),
        .disp  (if_nz.slave)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    // Anodes must never both be on, on either instance.
    always @(negedge clk) begin
        if (inv_en) begin
            chk("an_lz_not_00", {7'd0, (if_lz.AN == 2'b00)}, 8'h00);
            chk("an_nz_not_00", {7'd0, (if_nz.AN == 2'b00)}, 8'h00);
        end
    end

    task automatic set_count(input logic [3:0] v);
        if_lz.COUNT = v;
        if_nz.COUNT = v;
    endtask

    // One clock cycle, then compare both instances.
    task automatic cyc(input string tag,
                       input logic [1:0] an0, input logic [7:0] seg0,
                       input logic [1:0] an1, input logic [7:0] seg1);
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        $display("cyc %0d %s lz: an=%b seg=%h  nz: an=%b seg=%h",
                 cyc_no, tag, if_lz.AN, if_lz.SEG, if_nz.AN, if_nz.SEG);
        chk({tag, "_an_lz"},  {6'd0, if_lz.AN}, {6'd0, an0});
        chk({tag, "_seg_lz"}, if_lz.SEG, seg0);
        chk({tag, "_an_nz"},  {6'd0, if_nz.AN}, {6'd0, an1});
        chk({tag, "_seg_nz"}, if_nz.SEG, seg1);
    endtask

    // A full slot: one ghost cycle, then three lit (or expected) cycles.
    task automatic slot(input string tag,
                        input logic [1:0] an0, input logic [7:0] seg0,
                        input logic [1:0] an1, input logic [7:0] seg1);
        cyc({tag, "_ghost"}, AN_OFF, SEG_OFF, AN_OFF, SEG_OFF);
        repeat (SCAN_MAX - GHOST_CYC) cyc(tag, an0, seg0, an1, seg1);
    endtask

    // Hold reset for three cycles with COUNT applied, release between
    // edges, then expect the first slot to be fully dark.
    task automatic reset_seq(input string tag, input logic [3:0] v);
        rst_n = 1'b0;
        set_count(v);
        repeat (3) cyc({tag, "_rst"}, AN_OFF, SEG_OFF, AN_OFF, SEG_OFF);
        rst_n  = 1'b1;
        cyc_no = 0;
        slot({tag, "_first"}, AN_OFF, SEG_OFF, AN_OFF, SEG_OFF);
    endtask

    initial begin
        set_count(4'd0);

        // Reset behaviour and a two-digit value "13".
        reset_seq("s13", 4'd13);
        slot("s13_tens", AN_TENS, SEG_1, AN_TENS, SEG_1);
        slot("s13_ones", AN_ONES, SEG_3, AN_ONES, SEG_3);
        slot("s13_tens2", AN_TENS, SEG_1, AN_TENS, SEG_1);
        slot("s13_ones2", AN_ONES, SEG_3, AN_ONES, SEG_3);

        // Leading zero: "7" blanks the tens digit only with LZ_BLANK=1.
        reset_seq("s7", 4'd7);
        slot("s7_tens", AN_OFF, SEG_OFF, AN_TENS, SEG_0);
        slot("s7_ones", AN_ONES, SEG_7, AN_ONES, SEG_7);
        slot("s7_tens2", AN_OFF, SEG_OFF, AN_TENS, SEG_0);

        // Mid-slot change 9 -> 10 during a ones slot.
        reset_seq("s9", 4'd9);
        slot("s9_tens", AN_OFF, SEG_OFF, AN_TENS, SEG_0);
        cyc("s9_ones_ghost", AN_OFF, SEG_OFF, AN_OFF, SEG_OFF);
        cyc("s9_ones", AN_ONES, SEG_9, AN_ONES, SEG_9);
        set_count(4'd10);
        cyc("s9_ones_held", AN_ONES, SEG_9, AN_ONES, SEG_9);
        cyc("s9_ones_held", AN_ONES, SEG_9, AN_ONES, SEG_9);
        slot("s10_tens", AN_TENS, SEG_1, AN_TENS, SEG_1);
        slot("s10_ones", AN_ONES, SEG_0, AN_ONES, SEG_0);

        // Counter wrap 15 -> 0.
        reset_seq("s15", 4'd15);
        slot("s15_tens", AN_TENS, SEG_1, AN_TENS, SEG_1);
        slot("s15_ones", AN_ONES, SEG_5, AN_ONES, SEG_5);
        set_count(4'd0);
        slot("s15_tens2", AN_TENS, SEG_1, AN_TENS, SEG_1);
        slot("s0_ones", AN_ONES, SEG_0, AN_ONES, SEG_0);
        slot("s0_tens", AN_OFF, SEG_OFF, AN_TENS, SEG_0);

        // Asynchronous reset in the middle of a lit ones slot.
        reset_seq("sa", 4'd13);
        slot("sa_tens", AN_TENS, SEG_1, AN_TENS, SEG_1);
        cyc("sa_ones_ghost", AN_OFF, SEG_OFF, AN_OFF, SEG_OFF);
        cyc("sa_ones", AN_ONES, SEG_3, AN_ONES, SEG_3);
        #3;
        rst_n = 1'b0;
        #1;
        $display("async reset at %0t lz: an=%b seg=%h  nz: an=%b seg=%h",
                 $time, if_lz.AN, if_lz.SEG, if_nz.AN, if_nz.SEG);
        chk("async_an_lz",  {6'd0, if_lz.AN}, {6'd0, AN_OFF});
        chk("async_seg_lz", if_lz.SEG, SEG_OFF);
        chk("async_an_nz",  {6'd0, if_nz.AN}, {6'd0, AN_OFF});
        chk("async_seg_nz", if_nz.SEG, SEG_OFF);
        @(negedge clk);
        reset_seq("sa2", 4'd13);
        slot("sa2_tens", AN_TENS, SEG_1, AN_TENS, SEG_1);
        slot("sa2_ones", AN_ONES, SEG_3, AN_ONES, SEG_3);

        inv_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
